// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter onto a single load/store slave port.
// Writes go before reads within a master; stalled transactions are force-completed on timeout.
module lsu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_rready,
  input  logic        m0_wvalid,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_wdata,
  output logic        m0_rvalid,
  output logic        m0_wready,
  output logic [31:0] m0_rdata,
  input  logic        m1_rready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_wdata,
  output logic        m1_rvalid,
  output logic        m1_wready,
  output logic [31:0] m1_rdata,
  output logic        s_rready,
  output logic        s_wvalid,
  output logic [31:0] s_addr,
  output logic [3:0]  s_strb,
  output logic [31:0] s_wdata,
  input  logic        s_rvalid,
  input  logic        s_wready,
  input  logic [31:0] s_rdata,
  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_o
);

  // state | meaning
  // IDLE  | no transaction in flight, arbitrating between requesters
  // RD    | read issued to slave on behalf of owner
  // WR    | write issued to slave on behalf of owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic [15:0] cnt;

  logic        req0, req1, grant, grant_wr;
  logic        own_rready, own_wvalid, own_req;
  logic [31:0] own_addr, own_wdata;
  logic [3:0]  own_strb;
  logic        active, rd_done, wr_done, tmo, rd_resp, wr_resp;
  logic [31:0] resp_rdata;

  always_comb begin
    req0       = m0_rready | m0_wvalid;
    req1       = m1_rready | m1_wvalid;
    grant      = (req0 & req1) ? ~last_grant : req1;
    grant_wr   = grant ? m1_wvalid : m0_wvalid;

    own_rready = owner ? m1_rready : m0_rready;
    own_wvalid = owner ? m1_wvalid : m0_wvalid;
    own_addr   = owner ? m1_addr   : m0_addr;
    own_strb   = owner ? m1_strb   : m0_strb;
    own_wdata  = owner ? m1_wdata  : m0_wdata;
    own_req    = (state == RD) ? own_rready : own_wvalid;
    active     = (state != IDLE);

    // A real completion in the terminal-count cycle wins over the timeout.
    rd_done    = (state == RD) & own_rready & s_rvalid;
    wr_done    = (state == WR) & own_wvalid & s_wready;
    tmo        = active & own_req & ~rd_done & ~wr_done & (cnt == TMO_LAST);
    rd_resp    = rd_done | (tmo & (state == RD));
    wr_resp    = wr_done | (tmo & (state == WR));
    resp_rdata = rd_done ? s_rdata : (rd_resp ? TMO_RDATA : 32'h0);
  end

  assign s_rready  = (state == RD);
  assign s_wvalid  = (state == WR);
  assign s_addr    = active ? own_addr  : 32'h0;
  assign s_strb    = active ? own_strb  : 4'h0;
  assign s_wdata   = active ? own_wdata : 32'h0;

  assign m0_rvalid = rd_resp & ~owner;
  assign m1_rvalid = rd_resp & owner;
  assign m0_wready = wr_resp & ~owner;
  assign m1_wready = wr_resp & owner;
  assign m0_rdata  = m0_rvalid ? resp_rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? resp_rdata : 32'h0;

  assign busy_o    = active;
  assign owner_o   = owner;
  assign timeout_o = tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state <= grant_wr ? WR : RD;
            owner <= grant;
            cnt   <= 16'h0;
          end
        end
        RD, WR: begin
          // An abandoned request does not count as service for round-robin.
          if (!own_req) begin
            state <= IDLE;
          end else if (rd_resp | wr_resp) begin
            state      <= IDLE;
            last_grant <= owner;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, setting the number of busy cycles allowed before a transaction is force-completed; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports m0_rready / m1_rready  in  1  master read request, held until that master's rvalid.
REQ-005 SHALL have ports m0_wvalid / m1_wvalid  in  1  master write request, held until that master's wready.
REQ-006 SHALL have ports m0_addr / m1_addr  in  32  byte address.
REQ-007 SHALL have ports m0_strb / m1_strb  in  4  byte write strobe.
REQ-008 SHALL have ports m0_wdata / m1_wdata  in  32  write data.
REQ-009 SHALL have ports m0_rvalid / m1_rvalid  out  1  read completion pulse to that master.
REQ-010 SHALL have ports m0_wready / m1_wready  out  1  write completion pulse to that master.
REQ-011 SHALL have ports m0_rdata / m1_rdata  out  32  read data, valid with rvalid.
REQ-012 SHALL have ports s_rready, s_wvalid  out  1 each  slave-side request.
REQ-013 SHALL have ports s_addr (32), s_strb (4), s_wdata (32)  out  slave-side command.
REQ-014 SHALL have ports s_rvalid, s_wready  in  1 each  slave-side completion.
REQ-015 SHALL have port s_rdata  in  32  slave read data.
REQ-016 SHALL have ports busy_o  out  1  FSM not IDLE; owner_o  out  1  current or last owner index; timeout_o  out  1  one-cycle timeout pulse.

Function
REQ-017 SHALL implement FSM IDLE, RD, WR; owner register (1 bit); last_grant register (1 bit); timeout counter (16 bits).
REQ-018 In IDLE, a master is requesting when rready or wvalid is high; with one requester, it SHALL be granted; with two, the master not equal to last_grant SHALL be granted (round-robin).
REQ-019 A master asserting both wvalid and rready SHALL be served as a write first; the read stays pending.
REQ-020 Grant SHALL be registered: request seen at edge N moves FSM to RD/WR at N; slave request visible in cycle after N; counter cleared to 0.
REQ-021 In RD/WR, s_addr, s_strb, s_wdata SHALL combinationally follow the owner's inputs; s_rready (RD) or s_wvalid (WR) SHALL equal 1.
REQ-022 In IDLE, s_rready, s_wvalid, s_addr, s_strb, s_wdata SHALL all be 0.
REQ-023 s_rvalid in RD (s_wready in WR) SHALL be routed combinationally to the owner's rvalid (wready), with s_rdata routed to owner rdata the same cycle; FSM SHALL return to IDLE at that edge and last_grant SHALL become owner.
REQ-024 Non-owner rvalid/wready SHALL be 0 at all times; mX_rdata SHALL be 0 when mX_rvalid is 0.
REQ-025 Counter SHALL increment each RD/WR cycle without completion; when it equals TIMEOUT_CYCLES-1 without completion, the owner SHALL receive rvalid (rdata 32'hDEAD_BEEF) or wready, timeout_o SHALL pulse 1 cycle, slave request SHALL drop, FSM SHALL go IDLE, and last_grant SHALL become owner.
REQ-026 Completion and timeout in the same cycle SHALL be treated as completion; timeout_o stays 0 and slave data is forwarded.
REQ-027 If the owner drops its request before completion, FSM SHALL return to IDLE next edge with no response, no timeout_o, and last_grant unchanged.
REQ-028 At least one IDLE cycle SHALL separate consecutive transactions; minimum transaction cost = slave latency + 2 cycles.
REQ-029 s_rvalid/s_wready arriving in IDLE, or of the wrong type for the state, SHALL be ignored.

Reset
REQ-030 On rst_n low, asynchronously: FSM=IDLE, owner=0, last_grant=1 (m0 wins first contention), counter=0; all outputs 0.
REQ-031 Reset mid-transaction SHALL drop slave requests immediately; no completion SHALL be delivered to any master.

Verification
REQ-032 m0 read only, addr 0x100, slave rvalid 3 cycles after s_rready, rdata 0x1234_5678 -> m0_rvalid 1 cycle with 0x1234_5678, m1 outputs 0, busy_o falls next edge.
REQ-033 m0 and m1 write simultaneously after reset -> m0 served first, then m1 after 1 IDLE cycle; repeated contention alternates m0, m1, m0, m1.
REQ-034 TIMEOUT_CYCLES=4, m1 read, slave silent -> m1_rvalid with 0xDEAD_BEEF 4 cycles after grant, timeout_o pulse, s_rready low next cycle.
REQ-035 m0 asserts rready and wvalid together -> write completes first (s_wvalid, strb 4'b1111), then read.
REQ-036 rst_n low during m0 write with s_wvalid high -> s_wvalid 0 immediately, m0_wready never asserts; post-reset, contention grants m0.
REQ-037 Stray s_rvalid in IDLE and owner dropping rready mid-RD -> no mX_rvalid, FSM IDLE, last_grant unchanged.
